uart_rx: RTL and testbench

Serial receiver for 8N1 asynchronous UART: 1 start bit, 8 data bits LSB first, 1 stop bit, 9600 baud at 125 MHz by default. It takes the external RX pin, synchronises it into the clk domain and samples each bit at its centre. Each received byte is presented as a parallel word with a one-cycle valid pulse. It is the companion of uart_tx on the opposite end of the same serial link and uses the same bit period and frame format.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 105 ++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART link constants and FSM state encoding for uart_tx and uart_rx
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 13021;
  localparam int DATA_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START_BIT = 2'b01,
    DATA_BITS = 2'b10,
    STOP_BIT  = 2'b11
  } state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the rx pin plus falling-edge detect
// clk, rst (sync, active-low) | rx_line: async pin | rx_s: synchronised level | fall: rx_s went 1->0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_line,
  output logic rx_s,
  output logic fall
);
  logic r_meta, r_sync, r_prev;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= rx_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end
  assign rx_s = r_sync;
  assign fall = r_prev & ~r_sync;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling each bit at its centre
// clk, rst (sync, active-low) | rx_line: async serial input, idles high
// rx_data: last good byte | rx_valid: 1-cycle new-byte pulse | rx_frame_err: 1-cycle bad-stop pulse
// rx_active: high while a frame is being received
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_line,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_frame_err,
  output logic                  rx_active
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] TOP_BIT = BW'(DATA_WIDTH - 1);
  logic                  w_rx_s, w_fall;
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_clk, w_clk_nxt;
  logic [BW-1:0]         r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_ferr, w_ferr_nxt;
  logic                  w_last;
  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_line(rx_line),
    .rx_s   (w_rx_s),
    .fall   (w_fall)
  );
  assign w_last = (r_clk == LAST);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_clk   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clk   <= w_clk_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = w_fall ? START_BIT : IDLE;
      end
      START_BIT: begin
        // line back high at mid-start means the edge was a glitch
        if (r_clk == HALF) begin
          w_clk_nxt   = '0;
          w_state_nxt = w_rx_s ? IDLE : DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (w_last) begin
          w_clk_nxt            = '0;
          w_shift_nxt[r_bit]   = w_rx_s;
          w_bit_nxt            = (r_bit == TOP_BIT) ? r_bit : r_bit + 1'b1;
          w_state_nxt          = (r_bit == TOP_BIT) ? STOP_BIT : DATA_BITS;
        end
      end
      STOP_BIT: begin
        // return to IDLE at mid-stop so a start edge right after the stop bit is caught
        if (w_last) begin
          w_clk_nxt   = '0;
          w_state_nxt = IDLE;
          w_valid_nxt = w_rx_s;
          w_ferr_nxt  = ~w_rx_s;
          w_data_nxt  = w_rx_s ? r_shift : r_data;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_ferr;
  assign rx_active    = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_line = 1'b1;
  logic       rx_line2 = 1'b1;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, rx_valid2, rx_frame_err, rx_frame_err2, rx_active, rx_active2;
  int         total = 0, bad = 0;
  int         nv = 0, nf = 0, act = 0, nv2 = 0, nf2 = 0;
  logic [7:0] q[$], q2[$];

  always #4 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_active(rx_active)
  );

  uart_rx #(.CLKS_PER_BIT(100)) dut2 (
    .clk(clk), .rst(rst), .rx_line(rx_line2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .rx_frame_err(rx_frame_err2), .rx_active(rx_active2)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      nv++;
      q.push_back(rx_data);
    end
    if (rx_frame_err) nf++;
    if (rx_active) act++;
    if (rx_valid2) begin
      nv2++;
      q2.push_back(rx_data2);
    end
    if (rx_frame_err2) nf2++;
  end

  task automatic drive(input logic b, input int n, input bit sel);
    if (sel) rx_line2 = b;
    else rx_line = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int per, input bit sel);
    drive(1'b0, per, sel);
    for (int i = 0; i < 8; i++) drive(d[i], per, sel);
    drive(stop, per, sel);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total += 4;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
    if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", rx_frame_err); end
    if (rx_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", rx_active); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    int v = nv, f = nf, a = act;
    logic [7:0] d;
    send(8'h55, 1'b1, 16, 1'b0);
    drive(1'b1, 16, 1'b0);
    d = q.size() ? q.pop_front() : 8'hxx;
    total += 5;
    if (nv - v !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", nv - v); end
    if (d !== 8'h55) begin bad++; $display("FAIL single_byte got=%h want=55", d); end
    if (nf !== f) begin bad++; $display("FAIL single_ferr got=%0d want=0", nf - f); end
    if (act - a !== 152) begin bad++; $display("FAIL single_active got=%0d want=152", act - a); end
    if (rx_data !== 8'h55) begin bad++; $display("FAIL single_hold got=%h want=55", rx_data); end
  endtask

  task automatic test_back_to_back;
    int v = nv;
    logic [7:0] d0, d1;
    send(8'hA3, 1'b1, 16, 1'b0);
    send(8'h0F, 1'b1, 16, 1'b0);
    drive(1'b1, 16, 1'b0);
    d0 = q.size() ? q.pop_front() : 8'hxx;
    d1 = q.size() ? q.pop_front() : 8'hxx;
    total += 3;
    if (nv - v !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", nv - v); end
    if (d0 !== 8'hA3) begin bad++; $display("FAIL b2b_first got=%h want=a3", d0); end
    if (d1 !== 8'h0F) begin bad++; $display("FAIL b2b_second got=%h want=0f", d1); end
  endtask

  task automatic test_glitch;
    int v = nv, f = nf;
    logic [7:0] d;
    drive(1'b0, 5, 1'b0);
    drive(1'b1, 32, 1'b0);
    total += 3;
    if (nv !== v) begin bad++; $display("FAIL glitch_valid got=%0d want=0", nv - v); end
    if (nf !== f) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", nf - f); end
    if (rx_active !== 1'b0) begin bad++; $display("FAIL glitch_active got=%b want=0", rx_active); end
    send(8'h3C, 1'b1, 16, 1'b0);
    drive(1'b1, 16, 1'b0);
    d = q.size() ? q.pop_front() : 8'hxx;
    total += 1;
    if (d !== 8'h3C) begin bad++; $display("FAIL glitch_next got=%h want=3c", d); end
  endtask

  task automatic test_frame_err;
    int v, f;
    logic [7:0] d;
    send(8'h11, 1'b1, 16, 1'b0);
    drive(1'b1, 16, 1'b0);
    d = q.size() ? q.pop_front() : 8'hxx;
    total += 1;
    if (d !== 8'h11) begin bad++; $display("FAIL ferr_prior got=%h want=11", d); end
    v = nv;
    f = nf;
    send(8'h81, 1'b0, 16, 1'b0);
    drive(1'b0, 40 * 16, 1'b0);
    total += 4;
    if (nf - f !== 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", nf - f); end
    if (nv !== v) begin bad++; $display("FAIL ferr_valid got=%0d want=0", nv - v); end
    if (rx_data !== 8'h11) begin bad++; $display("FAIL ferr_hold got=%h want=11", rx_data); end
    if (rx_active !== 1'b0) begin bad++; $display("FAIL ferr_rearm got=%b want=0", rx_active); end
    drive(1'b1, 32, 1'b0);
    send(8'h7E, 1'b1, 16, 1'b0);
    drive(1'b1, 16, 1'b0);
    d = q.size() ? q.pop_front() : 8'hxx;
    total += 1;
    if (d !== 8'h7E) begin bad++; $display("FAIL ferr_next got=%h want=7e", d); end
  endtask

  task automatic test_reset_mid;
    int v = nv, f = nf;
    logic [7:0] c = 8'hC3;
    logic [7:0] d;
    drive(1'b0, 16, 1'b0);
    for (int i = 0; i < 4; i++) drive(c[i], 16, 1'b0);
    drive(c[4], 8, 1'b0);
    total += 1;
    if (rx_active !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", rx_active); end
    rst = 1'b0;
    @(negedge clk);
    total += 4;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_data got=%h want=00", rx_data); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", rx_valid); end
    if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL mid_ferr got=%b want=0", rx_frame_err); end
    if (rx_active !== 1'b0) begin bad++; $display("FAIL mid_rst_active got=%b want=0", rx_active); end
    rst = 1'b1;
    drive(1'b1, 48, 1'b0);
    total += 2;
    if (nv !== v) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", nv - v); end
    if (nf !== f) begin bad++; $display("FAIL mid_no_ferr got=%0d want=0", nf - f); end
    send(8'hC3, 1'b1, 16, 1'b0);
    drive(1'b1, 16, 1'b0);
    d = q.size() ? q.pop_front() : 8'hxx;
    total += 1;
    if (d !== 8'hC3) begin bad++; $display("FAIL mid_next got=%h want=c3", d); end
  endtask

  task automatic test_baud;
    int v = nv2, f = nf2;
    logic [7:0] d0, d1;
    drive(1'b1, 200, 1'b1);
    send(8'hE7, 1'b1, 102, 1'b1);
    drive(1'b1, 100, 1'b1);
    send(8'hE7, 1'b1, 98, 1'b1);
    drive(1'b1, 100, 1'b1);
    d0 = q2.size() ? q2.pop_front() : 8'hxx;
    d1 = q2.size() ? q2.pop_front() : 8'hxx;
    total += 4;
    if (nv2 - v !== 2) begin bad++; $display("FAIL baud_count got=%0d want=2", nv2 - v); end
    if (nf2 !== f) begin bad++; $display("FAIL baud_ferr got=%0d want=0", nf2 - f); end
    if (d0 !== 8'hE7) begin bad++; $display("FAIL baud_slow got=%h want=e7", d0); end
    if (d1 !== 8'hE7) begin bad++; $display("FAIL baud_fast got=%h want=e7", d1); end
  endtask

  task automatic test_loopback;
    int v = nv;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1'b1, 16, 1'b0);
      d = q.size() ? q.pop_front() : 8'hxx;
      total += 1;
      if (d !== 8'(i)) begin bad++; $display("FAIL loop_byte got=%h want=%h", d, 8'(i)); end
    end
    drive(1'b1, 16, 1'b0);
    total += 1;
    if (nv - v !== 256) begin bad++; $display("FAIL loop_count got=%0d want=256", nv - v); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_baud;
    test_loopback;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
